alu_pipe_param: RTL and testbench



---
 rtl/alu_pipe_param.sv | 171 +++++++++++++++++
 tb/tb_alu_pipe_param.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_param.sv
// Two-stage pipelined ALU with valid/ready handshakes, carry/borrow chaining and status flags.
// Stage 1 captures operands and the chain carry; stage 2 evaluates and registers result and flags.
module alu_pipe_param #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero_flag,
   output logic             carry_flag,
   output logic             neg_flag,
   output logic             ovf_flag,
   output logic             err_flag
);

   localparam int SHW = $clog2(WIDTH);

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             cy;
      logic             ovf;
      logic             err;
   } alu_t;

   // (WIDTH+1)-bit sum or difference; the top bit is carry-out or borrow.
   function automatic logic [WIDTH:0] arith(input logic [WIDTH-1:0] fa,
                                            input logic [WIDTH-1:0] fb,
                                            input logic [3:0]       fop,
                                            input logic             fcy);
      logic w_cin;
      w_cin = ((fop == 4'd11) || (fop == 4'd12)) && fcy;
      if ((fop == 4'd1) || (fop == 4'd12))
         return {1'b0, fa} - {1'b0, fb} - {{WIDTH{1'b0}}, w_cin};
      else
         return {1'b0, fa} + {1'b0, fb} + {{WIDTH{1'b0}}, w_cin};
   endfunction

   function automatic logic arith_cy(input logic [WIDTH-1:0] fa,
                                     input logic [WIDTH-1:0] fb,
                                     input logic [3:0]       fop,
                                     input logic             fcy);
      logic [WIDTH:0] w_t;
      w_t = arith(fa, fb, fop, fcy);
      return w_t[WIDTH];
   endfunction

   function automatic alu_t alu_eval(input logic [WIDTH-1:0] fa,
                                     input logic [WIDTH-1:0] fb,
                                     input logic [3:0]       fop,
                                     input logic             fcy);
      alu_t                    o;
      logic [WIDTH:0]          w_ar;
      logic [SHW-1:0]          w_sh;
      logic signed [WIDTH-1:0] w_sa;
      logic signed [WIDTH-1:0] w_sb;
      o    = '0;
      w_ar = arith(fa, fb, fop, fcy);
      w_sh = fb[SHW-1:0];
      w_sa = $signed(fa);
      w_sb = $signed(fb);
      case (fop)
         4'd0, 4'd11: begin
            o.res = w_ar[WIDTH-1:0];
            o.cy  = w_ar[WIDTH];
            o.ovf = (fa[WIDTH-1] == fb[WIDTH-1]) && (w_ar[WIDTH-1] != fa[WIDTH-1]);
         end
         4'd1, 4'd12: begin
            o.res = w_ar[WIDTH-1:0];
            o.cy  = w_ar[WIDTH];
            o.ovf = (fa[WIDTH-1] != fb[WIDTH-1]) && (w_ar[WIDTH-1] != fa[WIDTH-1]);
         end
         4'd2:    o.res = fa & fb;
         4'd3:    o.res = fa | fb;
         4'd4:    o.res = fa ^ fb;
         4'd5:    o.res = ~fa;
         4'd6:    o.res = {{(WIDTH-1){1'b0}}, (fa < fb)};
         4'd7:    o.res = fa << w_sh;
         4'd8:    o.res = fa >> w_sh;
         4'd9:    o.res = $unsigned(w_sa >>> w_sh);
         4'd10:   o.res = {{(WIDTH-1){1'b0}}, (w_sa < w_sb)};
         4'd13:   o.res = fb;
         default: o.err = 1'b1;
      endcase
      return o;
   endfunction

   logic             w_adv;
   logic             w_acc;
   logic             w_chain_op;
   logic             w_in_cy;
   alu_t             w_s2;

   logic             r_cy;
   logic             r_vld_p1;
   logic [WIDTH-1:0] r_a_p1;
   logic [WIDTH-1:0] r_b_p1;
   logic [3:0]       r_op_p1;
   logic             r_cy_p1;

   logic             r_vld_p2;
   logic [WIDTH-1:0] r_res_p2;
   logic             r_zero_p2;
   logic             r_cy_p2;
   logic             r_neg_p2;
   logic             r_ovf_p2;
   logic             r_err_p2;

   assign w_adv      = !r_vld_p2 || out_ready;
   assign in_ready   = w_adv;
   assign w_acc      = in_valid && w_adv;
   assign w_chain_op = (op_code == 4'd0) || (op_code == 4'd1) ||
                       (op_code == 4'd11) || (op_code == 4'd12);
   assign w_in_cy    = arith_cy(a, b, op_code, r_cy);
   assign w_s2       = alu_eval(r_a_p1, r_b_p1, r_op_p1, r_cy_p1);

   // Stage 1: operand capture; the op keeps the chain carry as it was before its own update
   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_a_p1  <= a;
         r_b_p1  <= b;
         r_op_p1 <= op_code;
         r_cy_p1 <= r_cy;
      end
   end

   // Stage 2: evaluate; result and flags only move when a real beat advances
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cy      <= 1'b0;
         r_vld_p1  <= 1'b0;
         r_vld_p2  <= 1'b0;
         r_res_p2  <= '0;
         r_zero_p2 <= 1'b0;
         r_cy_p2   <= 1'b0;
         r_neg_p2  <= 1'b0;
         r_ovf_p2  <= 1'b0;
         r_err_p2  <= 1'b0;
      end else begin
         if (w_acc && w_chain_op)
            r_cy <= w_in_cy;
         if (w_adv) begin
            r_vld_p1 <= in_valid;
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
               r_res_p2  <= w_s2.res;
               r_zero_p2 <= (w_s2.res == '0);
               r_cy_p2   <= w_s2.cy;
               r_neg_p2  <= w_s2.res[WIDTH-1];
               r_ovf_p2  <= w_s2.ovf;
               r_err_p2  <= w_s2.err;
            end
         end
      end
   end

   assign out_valid  = r_vld_p2;
   assign result     = r_res_p2;
   assign zero_flag  = r_zero_p2;
   assign carry_flag = r_cy_p2;
   assign neg_flag   = r_neg_p2;
   assign ovf_flag   = r_ovf_p2;
   assign err_flag   = r_err_p2;

endmodule

// File: tb/tb_alu_pipe_param.sv
// Scoreboard bench for alu_pipe_param at WIDTH=8 and WIDTH=32, driven concurrently.
// An integer-arithmetic reference model supplies expected results; a monitor pops and compares.
`timescale 1ns/1ps
module tb_alu_pipe_param;

   typedef struct {
      logic [31:0] res;
      logic        z, c, n, v, e;
      int          acc;
      bit          lat;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit done [2];

   task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g
      localparam int     W    = (gi == 0) ? 8 : 32;
      localparam longint MODS = 64'sd1 <<< W;
      localparam longint HALF = 64'sd1 <<< (W - 1);

      logic         rst = 1'b1;
      logic         in_valid = 1'b0;
      logic         in_ready;
      logic [W-1:0] a = '0;
      logic [W-1:0] b = '0;
      logic [3:0]   op_code = '0;
      logic         out_valid;
      logic         out_ready = 1'b0;
      logic [W-1:0] result;
      logic         zero_flag, carry_flag, neg_flag, ovf_flag, err_flag;

      alu_pipe_param #(.WIDTH(W)) u_dut (
         .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
         .a(a), .b(b), .op_code(op_code), .out_valid(out_valid), .out_ready(out_ready),
         .result(result), .zero_flag(zero_flag), .carry_flag(carry_flag),
         .neg_flag(neg_flag), .ovf_flag(ovf_flag), .err_flag(err_flag)
      );

      exp_t q[$];
      int   cyc = 0;
      int   mode = 0;
      int   stall_left = 0;
      bit   lat_on = 0;
      logic mcy = 1'b0;

      always @(posedge clk) cyc <= cyc + 1;

      // Reference: operands as plain integers, overflow as out-of-range signed value.
      function automatic exp_t model(input longint ua, input longint ub, input int op, input logic cy);
         exp_t   r;
         longint sa, sb, t, cin, u;
         int     sh;
         r   = '{res: 0, z: 0, c: 0, n: 0, v: 0, e: 0, acc: 0, lat: 0};
         sa  = (ua >= HALF) ? ua - MODS : ua;
         sb  = (ub >= HALF) ? ub - MODS : ub;
         sh  = int'(ub % W);
         cin = ((op == 11) || (op == 12)) ? longint'(cy) : 64'sd0;
         u   = 0;
         case (op)
            0, 11: begin
               u   = ua + ub + cin;
               r.c = (u >= MODS);
               u   = u % MODS;
               t   = sa + sb + cin;
               r.v = (t > HALF - 1) || (t < -HALF);
            end
            1, 12: begin
               r.c = (ua < ub + cin);
               u   = (ua + MODS - ub - cin) % MODS;
               t   = sa - sb - cin;
               r.v = (t > HALF - 1) || (t < -HALF);
            end
            2:  u = ua & ub;
            3:  u = ua | ub;
            4:  u = ua ^ ub;
            5:  u = MODS - 1 - ua;
            6:  u = (ua < ub) ? 1 : 0;
            7:  u = (ua << sh) % MODS;
            8:  u = ua >> sh;
            9:  begin t = sa >>> sh; u = (t < 0) ? t + MODS : t; end
            10: u = (sa < sb) ? 1 : 0;
            13: u = ub;
            default: r.e = 1'b1;
         endcase
         r.res = 32'(u);
         r.z   = (u == 0);
         r.n   = (u >= HALF);
         return r;
      endfunction

      function automatic exp_t mk(input longint r, input logic [4:0] f);
         exp_t x;
         x.res = 32'(r);
         {x.z, x.c, x.n, x.v, x.e} = f;
         x.acc = 0;
         x.lat = 0;
         return x;
      endfunction

      function automatic logic next_rdy();
         case (mode)
            0: return 1'b1;
            1: return ($urandom % 4) != 0;
            2: begin
               if (stall_left > 0) begin
                  stall_left--;
                  return 1'b0;
               end
               return 1'b1;
            end
            default: return 1'b0;
         endcase
      endfunction

      function automatic logic [W-1:0] rv();
         case ($urandom % 4)
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
         endcase
      endfunction

      task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [3:0] top,
                          input bit use_given, input exp_t given);
         exp_t m;
         m = model(longint'(ta), longint'(tb), int'(top), mcy);
         in_valid = 1'b1; a = ta; b = tb; op_code = top;
         for (int k = 0; k < 100; k++) begin
            out_ready = next_rdy();
            @(negedge clk);
            if (mode == 2 && !out_ready && out_valid)
               chk("bp_in_ready", in_ready, 0);
            if (in_ready) begin
               if ((top == 0) || (top == 1) || (top == 11) || (top == 12))
                  mcy = m.c;
               if (use_given) m = given;
               m.acc = cyc;
               m.lat = lat_on;
               q.push_back(m);
               @(posedge clk); #1;
               in_valid = 1'b0;
               return;
            end
            @(posedge clk); #1;
         end
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: in_ready never high, W=%0d", W);
         in_valid = 1'b0;
      endtask

      task automatic idle();
         in_valid  = 1'b0;
         out_ready = next_rdy();
         @(negedge clk);
         @(posedge clk); #1;
      endtask

      task automatic drain();
         for (int k = 0; k < 200; k++) begin
            if (q.size() == 0) break;
            idle();
         end
         n_cmp++;
         if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d beats still pending, W=%0d", q.size(), W);
            q.delete();
         end
      endtask

      // Monitor: handshake rule, stall stability, in-order result/flag checks.
      initial begin
         exp_t             ex;
         bit               prev_stall = 0;
         logic [W+4:0]     prev_obs = '0;
         int               first_cyc = 0;
         forever begin
            @(negedge clk);
            if (rst) begin
               prev_stall = 0;
               continue;
            end
            chk("in_ready", in_ready, !out_valid || out_ready);
            if (prev_stall) begin
               chk("stall_valid", out_valid, 1);
               chk("stall_hold", {result, zero_flag, carry_flag, neg_flag, ovf_flag, err_flag}, prev_obs);
            end
            if (out_valid && !prev_stall) first_cyc = cyc;
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL extra_beat: result %0h with nothing expected, W=%0d", result, W);
               end else begin
                  ex = q.pop_front();
                  chk("result", result, ex.res[W-1:0]);
                  chk("flags_zcnve", {zero_flag, carry_flag, neg_flag, ovf_flag, err_flag},
                      {ex.z, ex.c, ex.n, ex.v, ex.e});
                  if (ex.lat) chk("latency", first_cyc - ex.acc, 2);
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_obs   = {result, zero_flag, carry_flag, neg_flag, ovf_flag, err_flag};
         end
      end

      // Driver
      initial begin
         exp_t dummy;
         int   tbl [12][5] = '{
            '{200, 100,  0,  44, 5'b01000},
            '{100, 100,  0, 200, 5'b00110},
            '{255,   1,  0,   0, 5'b11000},
            '{  0,   0, 11,   1, 5'b00000},
            '{  0,   1,  1, 255, 5'b01100},
            '{  5,   0, 12,   4, 5'b00000},
            '{128,   3,  9, 240, 5'b00100},
            '{128,   3,  8,  16, 5'b00000},
            '{  1,   9,  7,   2, 5'b00000},
            '{255,   1, 10,   1, 5'b00000},
            '{255,   1,  6,   0, 5'b10000},
            '{  0,   0, 14,   0, 5'b10001}};
         dummy = mk(0, 5'b0);
         rst = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         chk("reset_out_valid", out_valid, 0);
         chk("reset_result_flags", {result, zero_flag, carry_flag, neg_flag, ovf_flag, err_flag}, 0);
         rst = 1'b0;

         if (gi == 0) begin
            mode = 0; lat_on = 1;
            for (int i = 0; i < 12; i++)
               send(W'(tbl[i][0]), W'(tbl[i][1]), 4'(tbl[i][2]), 1, mk(tbl[i][3], 5'(tbl[i][4])));
            drain();
            lat_on = 0;
         end

         // Backpressure: three stalled cycles mid-stream
         mode = 0;
         for (int i = 0; i < 5; i++) begin
            if (i == 2) begin stall_left = 3; mode = 2; end
            send(rv(), rv(), 4'($urandom % 16), 0, dummy);
         end
         drain();

         // Reset with two beats in flight and the chain carry set
         mode = 3;
         send('1, W'(1), 4'd0, 0, dummy);
         send(W'(15), W'(51), 4'd2, 0, dummy);
         rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
         @(posedge clk); #1;
         rst = 1'b0;
         q.delete();
         mcy = 1'b0;
         @(negedge clk);
         chk("post_rst_out_valid", out_valid, 0);
         chk("post_rst_result_flags", {result, zero_flag, carry_flag, neg_flag, ovf_flag, err_flag}, 0);
         @(posedge clk); #1;
         mode = 0; lat_on = 1;
         send(W'(1), W'(1), 4'd11, 1, mk(2, 5'b00000));
         drain();
         lat_on = 0;

         // Random traffic with random stalls on both sides
         mode = 1;
         for (int i = 0; i < 1000; i++) begin
            if (($urandom % 4) == 0) idle();
            send(rv(), rv(), 4'($urandom % 16), 0, dummy);
         end
         drain();
         done[gi] = 1'b1;
      end
   end

   initial begin
      wait (done[0] && done[1]);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
